io_input_responder: RTL and testbench

Memory-mapped input peripheral for the 16-bit pipelined core. It is the responder side of the core's data-memory load/store port for addresses 0xFFF0–0xFFF8. It synchronizes and debounces the board KEY and SW inputs and holds sticky press and change flags with write-1-to-clear semantics. It also drives a level interrupt request. Its read data feeds the top-level dmemout mux whenever SEL is high.

---
 rtl/io_input_responder.sv | 160 ++++++++++++++++
 tb/tb_io_input_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_responder.sv
// io_input_responder
//
// Memory-mapped input peripheral on the core's data-memory load/store port.
// Synchronizes and debounces the board KEY and SW inputs, keeps sticky
// press/overrun/change flags (write 1 to clear) and raises a level IRQ.
//
// Register map (full address match, byte addresses):
//   0xFFF0 KDATA  RO  debounced keys, 1 = pressed
//   0xFFF2 SDATA  RO  debounced switches
//   0xFFF4 KSTAT  W1C [KBITS-1:0] press sticky, [2*KBITS-1:KBITS] overrun sticky
//   0xFFF6 SSTAT  W1C [0] switch-change sticky
//   0xFFF8 IE     RW  [0] key interrupt enable, [1] switch interrupt enable
//
// Ports:
//   CLK      clock, all state changes on posedge
//   RESET_N  asynchronous active-low reset
//   ADDR     byte address from the core
//   WR       store strobe, qualified by ADDR
//   DIN      store data
//   DOUT     read data, combinational from ADDR and registers (0 on a miss)
//   SEL      high when ADDR hits one of the five registers
//   KEY      raw board keys, asynchronous, 0 = pressed
//   SW       raw board switches, asynchronous
//   IRQ      level interrupt request, combinational from registers
module io_input_responder #(
   parameter int DBITS           = 16,
   parameter int KBITS           = 4,
   parameter int SBITS           = 10,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNTBITS         = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [DBITS-1:0] ADDR,
   input  logic             WR,
   input  logic [DBITS-1:0] DIN,
   output logic [DBITS-1:0] DOUT,
   output logic             SEL,
   input  logic [KBITS-1:0] KEY,
   input  logic [SBITS-1:0] SW,
   output logic             IRQ
);

   localparam int NBITS = KBITS + SBITS;
   localparam logic [CNTBITS-1:0] CNT_MAX = CNTBITS'(DEBOUNCE_CYCLES - 1);

   localparam logic [DBITS-1:0] A_KDATA = DBITS'(16'hFFF0);
   localparam logic [DBITS-1:0] A_SDATA = DBITS'(16'hFFF2);
   localparam logic [DBITS-1:0] A_KSTAT = DBITS'(16'hFFF4);
   localparam logic [DBITS-1:0] A_SSTAT = DBITS'(16'hFFF6);
   localparam logic [DBITS-1:0] A_IE    = DBITS'(16'hFFF8);

   // Keys and switches share one debounce path; keys occupy the low bits and
   // are inverted up front so that internally 1 always means pressed.
   logic [NBITS-1:0]   raw;
   logic [NBITS-1:0]   sync_p0;
   logic [NBITS-1:0]   sync_p1;
   logic [NBITS-1:0]   stable;
   logic [NBITS-1:0]   upd;
   logic [CNTBITS-1:0] cnt [NBITS];

   logic [KBITS-1:0]   kpend;
   logic [KBITS-1:0]   kovr;
   logic               schg;
   logic [1:0]         ie;

   logic [KBITS-1:0]   kpress;
   logic               sw_evt;
   logic               wr_kstat;
   logic               wr_sstat;
   logic               wr_ie;
   logic [KBITS-1:0]   kpend_clr;
   logic [KBITS-1:0]   kovr_clr;
   logic               schg_clr;

   assign raw = {SW, ~KEY};

   // upd marks a bit whose synchronized value has differed from the stable
   // value for DEBOUNCE_CYCLES consecutive cycles; it is accepted this edge.
   always_comb begin
      upd = '0;
      for (int i = 0; i < NBITS; i++) begin
         upd[i] = (sync_p1[i] != stable[i]) && (cnt[i] == CNT_MAX);
      end
   end

   // Stage p0/p1: two-flop synchronizer, then debounce counter and stable value
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         stable  <= '0;
         for (int i = 0; i < NBITS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         for (int i = 0; i < NBITS; i++) begin
            if ((sync_p1[i] == stable[i]) || upd[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNTBITS'(1);
            end
         end
         stable <= (stable & ~upd) | (sync_p1 & upd);
      end
   end

   // Events are detected on the same edge the stable value changes, so the
   // sticky bits and IRQ appear together with the new KDATA/SDATA.
   assign kpress = upd[KBITS-1:0] & sync_p1[KBITS-1:0];
   assign sw_evt = |upd[NBITS-1:KBITS];

   assign wr_kstat = WR && (ADDR == A_KSTAT);
   assign wr_sstat = WR && (ADDR == A_SSTAT);
   assign wr_ie    = WR && (ADDR == A_IE);

   assign kpend_clr = wr_kstat ? DIN[KBITS-1:0]       : '0;
   assign kovr_clr  = wr_kstat ? DIN[2*KBITS-1:KBITS] : '0;
   assign schg_clr  = wr_sstat & DIN[0];

   // Stage p2: sticky status and enable registers; a simultaneous event wins
   // over a clearing write. Overrun looks at the press flag before this edge.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         kpend <= '0;
         kovr  <= '0;
         schg  <= 1'b0;
         ie    <= '0;
      end else begin
         kpend <= kpress | (kpend & ~kpend_clr);
         kovr  <= (kpress & kpend) | (kovr & ~kovr_clr);
         schg  <= sw_evt | (schg & ~schg_clr);
         if (wr_ie) begin
            ie <= DIN[1:0];
         end
      end
   end

   always_comb begin
      DOUT = '0;
      SEL  = 1'b0;
      case (ADDR)
         A_KDATA: begin SEL = 1'b1; DOUT = DBITS'(stable[KBITS-1:0]);     end
         A_SDATA: begin SEL = 1'b1; DOUT = DBITS'(stable[NBITS-1:KBITS]); end
         A_KSTAT: begin SEL = 1'b1; DOUT = DBITS'({kovr, kpend});         end
         A_SSTAT: begin SEL = 1'b1; DOUT = DBITS'(schg);                  end
         A_IE:    begin SEL = 1'b1; DOUT = DBITS'(ie);                    end
         default: begin SEL = 1'b0; DOUT = '0;                            end
      endcase
   end

   assign IRQ = (ie[0] & (|kpend)) | (ie[1] & schg);

   // Store-data bits above the widest writable register have no destination.
   logic unused_din;
   assign unused_din = ^DIN[DBITS-1:2*KBITS];

endmodule

// File: tb/tb_io_input_responder.sv
module tb_io_input_responder;

   localparam logic [15:0] A_KD = 16'hFFF0;
   localparam logic [15:0] A_SD = 16'hFFF2;
   localparam logic [15:0] A_KS = 16'hFFF4;
   localparam logic [15:0] A_SS = 16'hFFF6;
   localparam logic [15:0] A_IE = 16'hFFF8;

   logic        CLK;
   logic        RESET_N;
   logic [15:0] ADDR;
   logic        WR;
   logic [15:0] DIN;
   logic [15:0] DOUT;
   logic        SEL;
   logic [3:0]  KEY;
   logic [9:0]  SW;
   logic        IRQ;

   io_input_responder #(
      .DBITS(16), .KBITS(4), .SBITS(10), .DEBOUNCE_CYCLES(4), .CNTBITS(16)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .WR(WR), .DIN(DIN),
      .DOUT(DOUT), .SEL(SEL), .KEY(KEY), .SW(SW), .IRQ(IRQ)
   );

   initial begin
      CLK = 1'b0;
      forever #10 CLK = ~CLK;
   end

   typedef struct {
      string       nm;
      logic [15:0] addr;
      logic [15:0] data;
      logic        sel;
      logic        irq;
   } exp_t;

   exp_t sb[$];
   event rd_ev;
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic hit(input logic [15:0] a);
      return (a == A_KD) || (a == A_SD) || (a == A_KS) || (a == A_SS) || (a == A_IE);
   endfunction

   // Monitor: every presented read is popped and compared
   initial begin
      exp_t e;
      forever begin
         @(rd_ev);
         #1;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_underflow: read presented with no expectation queued");
         end else begin
            e = sb.pop_front();
            n_vec++;
            if (DOUT !== e.data || SEL !== e.sel || IRQ !== e.irq) begin
               n_err++;
               $display("FAIL %s addr=%h: got dout=%h sel=%b irq=%b, want dout=%h sel=%b irq=%b",
                        e.nm, e.addr, DOUT, SEL, IRQ, e.data, e.sel, e.irq);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rd(input string nm, input logic [15:0] a, input logic [15:0] d, input logic irq);
      exp_t e;
      ADDR   = a;
      e.nm   = nm;
      e.addr = a;
      e.data = d;
      e.sel  = hit(a);
      e.irq  = irq;
      sb.push_back(e);
      ->rd_ev;
      #2;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      ADDR = a;
      DIN  = d;
      WR   = 1'b1;
      tick();
      WR   = 1'b0;
   endtask

   initial begin
      RESET_N = 1'b0;
      KEY = 4'hF;
      SW = '0;
      ADDR = '0;
      WR = 1'b0;
      DIN = '0;
      #5;
      rd("rst_kdata", A_KD, 16'h0000, 1'b0);
      rd("rst_kstat", A_KS, 16'h0000, 1'b0);
      rd("rst_ie",    A_IE, 16'h0000, 1'b0);
      ticks(2);
      RESET_N = 1'b1;
      tick();

      // KEY[0] press: visible on the 6th edge counting the sampling edge
      KEY = 4'b1110;
      for (int k = 1; k <= 6; k++) begin
         tick();
         rd("kd_latency", A_KD, (k == 6) ? 16'h0001 : 16'h0000, 1'b0);
         rd("ks_latency", A_KS, (k == 6) ? 16'h0001 : 16'h0000, 1'b0);
      end

      // 3-cycle glitch on KEY[1] is ignored
      KEY = 4'b1100;
      ticks(3);
      KEY = 4'b1110;
      ticks(8);
      rd("glitch_kd", A_KD, 16'h0001, 1'b0);
      rd("glitch_ks", A_KS, 16'h0001, 1'b0);

      // a real KEY[1] press still needs the full debounce time afterwards
      KEY = 4'b1100;
      for (int k = 1; k <= 6; k++) begin
         tick();
         rd("k1_latency", A_KD, (k == 6) ? 16'h0003 : 16'h0001, 1'b0);
      end
      KEY = 4'b1110;
      ticks(8);
      rd("k1_rel_ks", A_KS, 16'h0003, 1'b0);
      wr(A_KS, 16'h0003);
      rd("ks_cleared", A_KS, 16'h0000, 1'b0);
      rd("miss_odd", 16'hFFF1, 16'h0000, 1'b0);

      // KEY[2] pressed twice without clearing -> press + overrun
      KEY = 4'b1010; ticks(8);
      KEY = 4'b1110; ticks(8);
      KEY = 4'b1010; ticks(8);
      KEY = 4'b1110; ticks(8);
      rd("ovr_ks", A_KS, 16'h0044, 1'b0);
      rd("ovr_kd", A_KD, 16'h0001, 1'b0);
      ADDR = A_KS; DIN = 16'h0004; WR = 1'b1;
      rd("w1c_same_cycle", A_KS, 16'h0044, 1'b0);
      tick();
      WR = 1'b0;
      rd("w1c_press", A_KS, 16'h0040, 1'b0);
      wr(A_KS, 16'h0040);
      rd("w1c_ovr", A_KS, 16'h0000, 1'b0);

      // switch change with both interrupts enabled
      wr(A_IE, 16'h0003);
      rd("ie_rd", A_IE, 16'h0003, 1'b0);
      SW = 10'h200;
      for (int k = 1; k <= 6; k++) begin
         tick();
         rd("sd_latency", A_SD, (k == 6) ? 16'h0200 : 16'h0000, k == 6);
         rd("ss_latency", A_SS, (k == 6) ? 16'h0001 : 16'h0000, k == 6);
      end
      ADDR = A_SS; DIN = 16'h0001; WR = 1'b1;
      rd("ss_w1c_same_cycle", A_SS, 16'h0001, 1'b1);
      tick();
      WR = 1'b0;
      rd("ss_cleared", A_SS, 16'h0000, 1'b0);

      // release sets nothing; a fresh press raises IRQ via IE[0]
      KEY = 4'b1111; ticks(8);
      rd("rel_kd", A_KD, 16'h0000, 1'b0);
      rd("rel_ks", A_KS, 16'h0000, 1'b0);
      KEY = 4'b1110; ticks(8);
      rd("press_irq", A_KS, 16'h0001, 1'b1);
      KEY = 4'b1111; ticks(8);

      // press event and W1C of KSTAT[0] on the same edge: set wins
      KEY = 4'b1110;
      ticks(5);
      ADDR = A_KS; DIN = 16'h0001; WR = 1'b1;
      tick();
      WR = 1'b0;
      rd("set_wins_ks", A_KS, 16'h0011, 1'b1);

      // asynchronous reset in the middle of a switch debounce
      SW = 10'h201;
      ticks(2);
      #1;
      RESET_N = 1'b0;
      rd("arst_kd",   A_KD, 16'h0000, 1'b0);
      rd("arst_sd",   A_SD, 16'h0000, 1'b0);
      rd("arst_ks",   A_KS, 16'h0000, 1'b0);
      rd("arst_ss",   A_SS, 16'h0000, 1'b0);
      rd("arst_ie",   A_IE, 16'h0000, 1'b0);
      rd("arst_miss", 16'hFFFA, 16'h0000, 1'b0);
      tick();
      RESET_N = 1'b1;

      // inputs already active at reset release are reported once debounced
      for (int k = 1; k <= 6; k++) begin
         tick();
         rd("post_rst_sd", A_SD, (k == 6) ? 16'h0201 : 16'h0000, 1'b0);
         rd("post_rst_ss", A_SS, (k == 6) ? 16'h0001 : 16'h0000, 1'b0);
         rd("post_rst_ks", A_KS, (k == 6) ? 16'h0001 : 16'h0000, 1'b0);
      end

      #5;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL sb_leftover: %0d expectations not consumed, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
